// File: rtl/music_pkg.sv
// Shared types and default sizing for the song sample reader.
package music_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      CAPTURE,
      PRESENT,
      WAIT_TICK,
      DONE
   } music_state_t;

   localparam int MUSIC_ADDR_W   = 17;
   localparam int MUSIC_DATA_W   = 17;
   localparam int MUSIC_SONG_LEN = 80550;
   localparam int MUSIC_CLK_DIV  = 3125;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: one-cycle tick every CLK_DIV enabled cycles, cleared on clr.
module sample_tick_gen #(
   parameter int CLK_DIV = 3125
) (
   input  logic Clk,
   input  logic Reset,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] r_div;

   always_ff @(posedge Clk) begin
      if (Reset || clr) begin
         r_div <= '0;
      end else if (en) begin
         if (r_div == LAST) r_div <= '0;
         else               r_div <= r_div + DIV_W'(1);
      end
   end

   assign tick = en && (r_div == LAST);

endmodule

// File: rtl/music_player.sv
// Steps through the song ROM at the sample rate and offers each word over valid/ready.
// Optional MUSIC_VOLUME_EN adds vol_shift, a right-shift attenuation applied at capture.
module music_player
   import music_pkg::*;
#(
   parameter int SONG_LEN = MUSIC_SONG_LEN,
   parameter int ADDR_W   = MUSIC_ADDR_W,
   parameter int DATA_W   = MUSIC_DATA_W,
   parameter int CLK_DIV  = MUSIC_CLK_DIV
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              play,
   input  logic              stop,
   input  logic              loop_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
`ifdef MUSIC_VOLUME_EN
   input  logic [2:0]        vol_shift,
`endif
   output logic [DATA_W-1:0] sample_data,
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic              playing,
   output logic              done,
   output logic [7:0]        overrun_cnt
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

   music_state_t      r_state;
   logic [ADDR_W-1:0] r_rom_addr;
   logic [DATA_W-1:0] r_sample_data;
   logic              r_sample_valid;
   logic [7:0]        r_overrun_cnt;

   logic w_idle_or_done;
   logic w_clr;
   logic w_tick;
   logic w_busy;
   logic [DATA_W-1:0] w_scaled;

   assign w_idle_or_done = (r_state == IDLE) || (r_state == DONE);
   assign w_clr  = play && !stop && w_idle_or_done;
   assign w_busy = (r_state == FETCH) || (r_state == CAPTURE) || (r_state == PRESENT);

`ifdef MUSIC_VOLUME_EN
   assign w_scaled = rom_data >> vol_shift;
`else
   assign w_scaled = rom_data;
`endif

   sample_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .Clk   (Clk),
      .Reset (Reset),
      .clr   (w_clr),
      .en    (!w_idle_or_done),
      .tick  (w_tick)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state        <= IDLE;
         r_rom_addr     <= '0;
         r_sample_data  <= '0;
         r_sample_valid <= 1'b0;
         r_overrun_cnt  <= '0;
      end else if (stop) begin
         r_state        <= IDLE;
         r_rom_addr     <= '0;
         r_sample_valid <= 1'b0;
      end else begin
         // A tick that lands while a sample is still in flight is dropped, not queued.
         if (w_tick && w_busy && (r_overrun_cnt != 8'hFF))
            r_overrun_cnt <= r_overrun_cnt + 8'd1;

         case (r_state)
            IDLE: begin
               r_rom_addr <= '0;
               if (play) r_state <= FETCH;
            end
            FETCH:   r_state <= CAPTURE;
            CAPTURE: begin
               r_sample_data <= w_scaled;
               r_state       <= PRESENT;
            end
            PRESENT: begin
               // valid rises one cycle into PRESENT and falls on the accepting edge
               if (!r_sample_valid) begin
                  r_sample_valid <= 1'b1;
               end else if (sample_ready) begin
                  r_sample_valid <= 1'b0;
                  if (r_rom_addr == LAST_ADDR) begin
                     if (loop_en) begin
                        r_rom_addr <= '0;
                        r_state    <= WAIT_TICK;
                     end else begin
                        r_state <= DONE;
                     end
                  end else begin
                     r_rom_addr <= r_rom_addr + ADDR_W'(1);
                     r_state    <= WAIT_TICK;
                  end
               end
            end
            WAIT_TICK: if (w_tick) r_state <= FETCH;
            DONE: begin
               if (play) begin
                  r_rom_addr <= '0;
                  r_state    <= FETCH;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign rom_addr     = r_rom_addr;
   assign sample_data  = r_sample_data;
   assign sample_valid = r_sample_valid;
   assign playing      = !w_idle_or_done;
   assign done         = (r_state == DONE);
   assign overrun_cnt  = r_overrun_cnt;

endmodule

// File: tb/tb_music_player.sv
// Scoreboard bench for music_player with a 4-word ROM and an 8-cycle sample period.
module tb_music_player;

   localparam int SONG_LEN = 4;
   localparam int CLK_DIV  = 8;
`ifdef MUSIC_VOLUME_EN
   localparam int VOL = 2;
`else
   localparam int VOL = 0;
`endif

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        play = 1'b0;
   logic        stop = 1'b0;
   logic        loop_en = 1'b0;
   logic [16:0] rom_addr;
   logic [16:0] rom_data = '0;
   logic [16:0] sample_data;
   logic        sample_valid;
   logic        sample_ready = 1'b1;
   logic        playing;
   logic        done;
   logic [7:0]  overrun_cnt;
`ifdef MUSIC_VOLUME_EN
   logic [2:0]  vol_shift = 3'(VOL);
`endif

   logic [16:0] rom_mem [0:3];
   logic [16:0] exp_q [$];
   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;

   music_player #(
      .SONG_LEN (SONG_LEN),
      .ADDR_W   (17),
      .DATA_W   (17),
      .CLK_DIV  (CLK_DIV)
   ) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .play         (play),
      .stop         (stop),
      .loop_en      (loop_en),
      .rom_addr     (rom_addr),
      .rom_data     (rom_data),
`ifdef MUSIC_VOLUME_EN
      .vol_shift    (vol_shift),
`endif
      .sample_data  (sample_data),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .playing      (playing),
      .done         (done),
      .overrun_cnt  (overrun_cnt)
   );

   always #5 Clk = ~Clk;

   // ROM with one-cycle registered read
   always @(posedge Clk) rom_data <= rom_mem[rom_addr[1:0]];
   always @(posedge Clk) cyc <= cyc + 1;

   function automatic logic [16:0] scale(input logic [16:0] w);
      return w >> VOL;
   endfunction

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (sample_valid) begin
            ok = 1'b1;
            return;
         end
         step();
      end
      ok = sample_valid;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (3) step();
      Reset = 1'b0;
      n_checks++; if (rom_addr !== 17'd0) begin n_fail++; $display("FAIL reset_addr got %h expected 0", rom_addr); end
      n_checks++; if (sample_data !== 17'd0) begin n_fail++; $display("FAIL reset_data got %h expected 0", sample_data); end
      n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b expected 0", sample_valid); end
      n_checks++; if (playing !== 1'b0) begin n_fail++; $display("FAIL reset_playing got %b expected 0", playing); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b expected 0", done); end
      n_checks++; if (overrun_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_overrun got %0d expected 0", overrun_cnt); end
   endtask

   task automatic test_basic();
      bit ok;
      int t_prev;
      logic [16:0] exp;
      for (int i = 0; i < 4; i++) exp_q.push_back(scale(rom_mem[i]));
      play = 1'b1; step(); play = 1'b0;
      step(); step();
      n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got %b expected 0", sample_valid); end
      step();
      n_checks++; if (sample_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency got %b expected 1", sample_valid); end
      t_prev = 0;
      for (int i = 0; i < 4; i++) begin
         wait_valid(16, ok);
         n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_timeout sample %0d got none expected valid", i); end
         if (ok && exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            $display("basic sample %0d addr=%0d data=%h", i, rom_addr, sample_data);
            n_checks++; if (sample_data !== exp) begin n_fail++; $display("FAIL basic_data %0d got %h expected %h", i, sample_data, exp); end
            if (i > 0) begin
               n_checks++; if (cyc - t_prev != CLK_DIV) begin n_fail++; $display("FAIL basic_spacing %0d got %0d expected %0d", i, cyc - t_prev, CLK_DIV); end
            end
            t_prev = cyc;
         end
         step();
         n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop %0d got %b expected 0", i, sample_valid); end
      end
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done got %b expected 1", done); end
      n_checks++; if (playing !== 1'b0) begin n_fail++; $display("FAIL basic_playing got %b expected 0", playing); end
      n_checks++; if (rom_addr !== 17'd3) begin n_fail++; $display("FAIL basic_last_addr got %0d expected 3", rom_addr); end
   endtask

   task automatic test_loop();
      bit ok;
      logic [16:0] exp;
      loop_en = 1'b1;
      for (int i = 0; i < 6; i++) exp_q.push_back(scale(rom_mem[i % 4]));
      play = 1'b1; step(); play = 1'b0;
      for (int i = 0; i < 6; i++) begin
         wait_valid(16, ok);
         n_checks++; if (!ok) begin n_fail++; $display("FAIL loop_timeout sample %0d got none expected valid", i); end
         if (ok && exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            $display("loop sample %0d addr=%0d data=%h", i, rom_addr, sample_data);
            n_checks++; if (sample_data !== exp) begin n_fail++; $display("FAIL loop_data %0d got %h expected %h", i, sample_data, exp); end
         end
         step();
      end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL loop_done got %b expected 0", done); end
      n_checks++; if (playing !== 1'b1) begin n_fail++; $display("FAIL loop_playing got %b expected 1", playing); end
      stop = 1'b1; step(); stop = 1'b0; loop_en = 1'b0;
      exp_q.delete();
      n_checks++; if (rom_addr !== 17'd0) begin n_fail++; $display("FAIL loop_stop_addr got %0d expected 0", rom_addr); end
   endtask

   task automatic test_backpressure();
      bit ok;
      int t0;
      int bad;
      logic [16:0] first;
      logic [16:0] exp;
      sample_ready = 1'b0;
      exp_q.push_back(scale(rom_mem[0]));
      exp_q.push_back(scale(rom_mem[1]));
      play = 1'b1; step(); play = 1'b0;
      t0 = cyc;
      wait_valid(8, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_timeout got none expected valid"); end
      first = exp_q.pop_front();
      $display("backpressure first addr=%0d data=%h", rom_addr, sample_data);
      n_checks++; if (sample_data !== first) begin n_fail++; $display("FAIL bp_first got %h expected %h", sample_data, first); end
      bad = 0;
      while (cyc - t0 < 19) begin
         step();
         if (sample_data !== first || sample_valid !== 1'b1) bad++;
      end
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold got %0d bad cycles expected 0", bad); end
      n_checks++; if (overrun_cnt !== 8'd2) begin n_fail++; $display("FAIL bp_overrun got %0d expected 2", overrun_cnt); end
      sample_ready = 1'b1;
      step();
      wait_valid(16, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_next_timeout got none expected valid"); end
      exp = exp_q.pop_front();
      $display("backpressure next addr=%0d data=%h", rom_addr, sample_data);
      n_checks++; if (sample_data !== exp) begin n_fail++; $display("FAIL bp_next got %h expected %h", sample_data, exp); end
      n_checks++; if (overrun_cnt !== 8'd2) begin n_fail++; $display("FAIL bp_overrun_hold got %0d expected 2", overrun_cnt); end
      stop = 1'b1; step(); stop = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_stop_priority();
      bit ok;
      logic [16:0] exp;
      exp_q.push_back(scale(rom_mem[0]));
      play = 1'b1; step(); play = 1'b0;
      wait_valid(8, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL stop_timeout got none expected valid"); end
      exp = exp_q.pop_front();
      n_checks++; if (sample_data !== exp) begin n_fail++; $display("FAIL stop_first got %h expected %h", sample_data, exp); end
      step();
      wait_valid(16, ok);
      n_checks++; if (rom_addr !== 17'd1) begin n_fail++; $display("FAIL stop_pre_addr got %0d expected 1", rom_addr); end
      play = 1'b1; stop = 1'b1; step(); play = 1'b0; stop = 1'b0;
      $display("stop issued in PRESENT, addr=%0d valid=%b", rom_addr, sample_valid);
      n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL stop_valid got %b expected 0", sample_valid); end
      n_checks++; if (playing !== 1'b0) begin n_fail++; $display("FAIL stop_playing got %b expected 0", playing); end
      n_checks++; if (rom_addr !== 17'd0) begin n_fail++; $display("FAIL stop_addr got %0d expected 0", rom_addr); end
      exp_q.delete();
   endtask

   task automatic test_midop_reset();
      int bad;
      play = 1'b1; step(); play = 1'b0;
      step();
      Reset = 1'b1; step(); Reset = 1'b0;
      $display("reset in CAPTURE, overrun=%0d playing=%b", overrun_cnt, playing);
      n_checks++; if (overrun_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_overrun got %0d expected 0", overrun_cnt); end
      n_checks++; if (playing !== 1'b0) begin n_fail++; $display("FAIL mid_playing got %b expected 0", playing); end
      n_checks++; if (sample_data !== 17'd0) begin n_fail++; $display("FAIL mid_data got %h expected 0", sample_data); end
      n_checks++; if (rom_addr !== 17'd0) begin n_fail++; $display("FAIL mid_addr got %0d expected 0", rom_addr); end
      bad = 0;
      repeat (6) begin
         if (sample_valid !== 1'b0) bad++;
         step();
      end
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL mid_no_sample got %0d valid cycles expected 0", bad); end
   endtask

   initial begin
      rom_mem[0] = 17'h00011;
      rom_mem[1] = 17'h00022;
      rom_mem[2] = 17'h00033;
      rom_mem[3] = 17'h00044;
      test_reset();
      test_basic();
      test_loop();
      test_backpressure();
      test_stop_priority();
      test_midop_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
